// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: direction encodings and load clamping.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Loads above the modulus saturate at the highest legal count.
   function automatic int unsigned clamp_load(input int unsigned val, input int unsigned max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/timebase_prescaler.sv
// Free-running divider producing a one-cycle tick once every 2^DIV_BITS clocks.
// Latency: tick is high while the divider sits at all ones, then it rolls over.
// Backpressure: none; the divider always runs.
module timebase_prescaler #(
   parameter int DIV_BITS = 24
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   logic [DIV_BITS-1:0] div_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = &div_cnt;

endmodule

// File: rtl/param_updown_counter.sv
// Modulo-(MAX+1) up/down counter with load, enable and terminal-count pulse; build with COUNTER_PRESCALER_EN for a slow step tick.
// Latency: load and step results appear on count one cycle after the edge; tc follows the wrapping edge by one cycle.
// Backpressure: none; en gates stepping, load always wins.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX       = 15,
   parameter int RESET_VAL = 15,
   parameter int DIV_BITS  = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             tick
);

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
   localparam int unsigned      MAX_U   = MAX;

   if (MAX < 1 || MAX > (1 << WIDTH) - 1) begin : g_bad_max
      $error("param_updown_counter: MAX out of range");
   end
   if (RESET_VAL < 0 || RESET_VAL > MAX) begin : g_bad_reset_val
      $error("param_updown_counter: RESET_VAL must not exceed MAX");
   end
   if (DIV_BITS < 1) begin : g_bad_div_bits
      $error("param_updown_counter: DIV_BITS must be at least 1");
   end

`ifdef COUNTER_PRESCALER_EN
   timebase_prescaler #(
      .DIV_BITS (DIV_BITS)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );
`else
   assign tick = 1'b1;
`endif

   logic step;
   assign step = en & tick;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= RESET_V;
         tc    <= 1'b0;
      end else if (load) begin
         count <= WIDTH'(clamp_load(32'(load_val), MAX_U));
         tc    <= 1'b0;
      end else if (step) begin
         if (up_dn == DIR_UP) begin
            // >= so an out-of-range value still wraps cleanly to zero
            if (count >= MAX_V) begin
               count <= '0;
               tc    <= 1'b1;
            end else begin
               count <= count + 1'b1;
               tc    <= 1'b0;
            end
         end else begin
            if (count == '0) begin
               count <= MAX_V;
               tc    <= 1'b1;
            end else begin
               count <= count - 1'b1;
               tc    <= 1'b0;
            end
         end
      end else begin
         tc <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter (WIDTH=4, MAX=9, RESET_VAL=9, DIV_BITS=2): scripted checks plus randomized traffic against a modulo-arithmetic model.
module tb_param_updown_counter;

`ifdef COUNTER_PRESCALER_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif
   localparam int P_DIV  = 2;
   localparam int P_MAX  = 9;
   localparam int P_RST  = 9;
   localparam int PERIOD = 1 << P_DIV;

   logic       clk;
   logic       reset;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tc;
   logic       tick;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int m_count = P_RST;
   int m_tc    = 0;
   int m_cyc   = 0;
   bit stepped = 1'b0;

   param_updown_counter #(
      .WIDTH     (4),
      .MAX       (P_MAX),
      .RESET_VAL (P_RST),
      .DIV_BITS  (P_DIV)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .tick     (tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
      end
   endtask

   function automatic int exp_tick(input int cyc);
      return PRE ? ((cyc % PERIOD) == PERIOD - 1) : 1;
   endfunction

   // Model update from the inputs sampled at the edge, then compare shortly after.
   always @(posedge clk) begin
      bit tk;
      if (!reset) begin
         m_count = P_RST;
         m_tc    = 0;
         m_cyc   = 0;
         stepped = 1'b0;
      end else begin
         tk      = exp_tick(m_cyc) != 0;
         stepped = 1'b0;
         if (load) begin
            m_count = (int'(load_val) > P_MAX) ? P_MAX : int'(load_val);
            m_tc    = 0;
         end else if (en && tk) begin
            stepped = 1'b1;
            if (up_dn) begin
               m_tc    = (m_count == P_MAX);
               m_count = (m_count + 1) % (P_MAX + 1);
            end else begin
               m_tc    = (m_count == 0);
               m_count = (m_count + P_MAX) % (P_MAX + 1);
            end
         end else begin
            m_tc = 0;
         end
         m_cyc++;
      end
      #2;
      chk("model_count", int'(count), m_count);
      chk("model_tc", int'(tc), m_tc);
      chk("model_tick", int'(tick), exp_tick(m_cyc));
   end

   // Advance to the negedge following the next edge that applied a step.
   task automatic adv_step();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!stepped && n < 4 * PERIOD);
      if (!stepped) chk("step_timeout", 0, 1);
   endtask

   initial begin
      reset    = 1'b0;
      en       = 1'b0;
      up_dn    = 1'b0;
      load     = 1'b0;
      load_val = '0;
      repeat (3) @(negedge clk);
      chk("rst_count", int'(count), 9);
      chk("rst_tc", int'(tc), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_hold", int'(count), 9);

      // Down count through the wrap
      en = 1'b1;
      up_dn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         adv_step();
         chk("down_count", int'(count), (i < 9) ? 8 - i : 9);
         chk("down_tc", int'(tc), (i == 9) ? 1 : 0);
      end

      // Load 7, count up through the wrap, then reverse
      load = 1'b1;
      load_val = 4'd7;
      @(negedge clk);
      load = 1'b0;
      up_dn = 1'b1;
      chk("load7", int'(count), 7);
      adv_step(); chk("up8", int'(count), 8); chk("up8_tc", int'(tc), 0);
      adv_step(); chk("up9", int'(count), 9);
      adv_step(); chk("up_wrap", int'(count), 0); chk("up_wrap_tc", int'(tc), 1);
      up_dn = 1'b0;
      adv_step(); chk("dn_from0", int'(count), 9); chk("dn_from0_tc", int'(tc), 1);

      // Load priority over step, clamp above MAX
      load = 1'b1;
      load_val = 4'd12;
      @(negedge clk);
      chk("clamp", int'(count), 9);
      chk("clamp_tc", int'(tc), 0);
      load_val = 4'd3;
      @(negedge clk);
      chk("load3", int'(count), 3);
      load = 1'b0;
      en = 1'b0;

      // Enable gating
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("frozen", int'(count), 3);
         chk("frozen_tc", int'(tc), 0);
      end
      en = 1'b1;
      up_dn = 1'b1;
      adv_step();
      chk("resume", int'(count), 4);

      // Asynchronous reset between clock edges
      #3 reset = 1'b0;
      #1;
      chk("async_rst_count", int'(count), 9);
      chk("async_rst_tc", int'(tc), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_release_hold", int'(count), 9);
      end

      // Randomized traffic, loads include values above MAX
      for (int i = 0; i < 400; i++) begin
         en       = ($urandom_range(0, 3) != 0);
         up_dn    = $urandom_range(0, 1) != 0;
         load     = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      load = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the fixed 4-bit count-down counter that drives the board LEDs.
- Provides width, modulus and reset value as parameters, plus run-time up/down direction, count enable, synchronous load, and a one-cycle terminal-count pulse.
- An optional built-in prescaler generates the slow LED-rate step from the fast board clock.
- Sits between the board clock/KEY reset and LED or 7-seg display logic; a top-level wrapper instantiates it.

Parameters:
- WIDTH, 4: counter width in bits.
- MAX, 15: highest count value; counting is modulo MAX+1. Range 1..2^WIDTH-1.
- RESET_VAL, 15: count value after reset. Must be <= MAX.
- DIV_BITS, 24: prescaler width; one step per 2^DIV_BITS clocks. Used only with COUNTER_PRESCALER_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  count enable
- up_dn  in  1  direction: 1 = up, 0 = down
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered
- tick  out  1  step strobe actually used by the counter

Behaviour:
- Interface decision: one clock (clk). Reset (reset) is asynchronous and active-low.
- While reset is low:
  - count = RESET_VAL, tc = 0, prescaler = 0.
  - Assertion takes effect immediately, without waiting for a clock edge.
  - Deassertion is honoured at the next rising clk.
- step = en & tick, evaluated each rising clk.
- Priority per edge: load > step > hold.
- Load:
  - count <= min(load_val, MAX); values above MAX clamp to MAX.
  - tc <= 0.
  - The load takes effect regardless of en/tick and does not touch the prescaler.
- Step, up (up_dn = 1):
  - If count == MAX: count <= 0, tc <= 1.
  - Else: count <= count + 1, tc <= 0.
- Step, down (up_dn = 0):
  - If count == 0: count <= MAX, tc <= 1.
  - Else: count <= count - 1, tc <= 0.
- Hold (no load, no step): count unchanged, tc <= 0.
- tc is therefore high for exactly one clk cycle, in the cycle after the wrapping edge.
- up_dn may change on any cycle; the value sampled at the stepping edge decides the direction.
- Latency:
  - load_val is visible on count one cycle after the load edge.
  - A step is visible on count one cycle after the step edge.
- Arithmetic: WIDTH-bit unsigned; no intermediate values wider than WIDTH+1 bits.
- If count ever holds a value above MAX (not reachable in normal operation): an up step wraps to 0 with tc; a down step decrements normally.

Optional Feature:
- Macro: COUNTER_PRESCALER_EN.
- Defined:
  - A free-running DIV_BITS counter increments every clk and resets to 0.
  - tick = 1 for one cycle when the prescaler is all ones, i.e. once every 2^DIV_BITS cycles. With the defaults and a 50 MHz clock this is about 3 Hz.
  - en gates only the counter step; the prescaler always runs.
- Undefined:
  - tick is tied to 1, so the counter steps on every clk where en = 1.
  - DIV_BITS is ignored and no prescaler flops are built.

Decomposition:
- Package counter_pkg holds:
  - constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0;
  - a function for clamping load values against MAX.
- One natural sub-module: timebase_prescaler (param DIV_BITS; ports clk, reset, tick). It is instantiated only under COUNTER_PRESCALER_EN.

Test Plan (WIDTH = 4, MAX = 9, RESET_VAL = 9; prescaler variant uses DIV_BITS = 2):
- Reset: hold reset low mid-count -> count = 9 and tc = 0 immediately, without waiting for a clock edge; release -> count stays 9 until the first step.
- Down wrap: en = 1, up_dn = 0, 10 steps -> count 8..0, then 9 with tc = 1 for exactly one cycle; tc = 0 on all other cycles.
- Up wrap and direction change: load 7, up_dn = 1 -> 8, 9, 0 with tc pulse; flip up_dn = 0 -> 9 with tc pulse (down wrap from 0).
- Load priority and clamp: load = 1 with en = 1 and load_val = 12 on the same edge -> count = 9, tc = 0, no step applied; load_val = 3 -> count = 3.
- Enable gating: en = 0 for 5 cycles -> count frozen and tc = 0; re-enable -> stepping resumes on the next edge.
- Prescaler (COUNTER_PRESCALER_EN): en = 1 -> tick every 4th clk and count changes only on those edges; load between ticks takes effect immediately without shifting tick phase.
